// File: rtl/conv_pkg.sv
// Shared types and constant helpers for the convolution control path.
package conv_pkg;

    // Pass-level state of the patch scheduler.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of valid window positions along one dimension.
    function automatic int out_dim(input int img, input int k, input int stride);
        return (img - k) / stride + 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up-counter from 0 to MAX that wraps back to 0; clr has priority over en.
module wrap_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    // Count register: clear on a new pass, step or wrap when enabled.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == MAX_V) ? '0 : r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign wrap  = (r_count == MAX_V);

endmodule

// File: rtl/conv_patch_scheduler.sv
// Raster-order patch scheduler: produces input-window base and output address
// for each convolution patch, advancing one patch per adv pulse.
module conv_patch_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              adv,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W-1:0] patch_row,
    output logic [ADDR_W-1:0] patch_col,
    output logic              last_patch
);

    localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, K, STRIDE);

    // Address increments are elaboration constants, so no runtime multiplier exists.
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);

    // Reject geometries the address path cannot represent.
    if (K > IMG_W || K > IMG_H) begin : g_bad_kernel
        $error("conv_patch_scheduler: K must not exceed IMG_W or IMG_H");
    end
    if (STRIDE < 1) begin : g_bad_stride
        $error("conv_patch_scheduler: STRIDE must be at least 1");
    end
    if ((longint'(IMG_W) * longint'(IMG_H) - 1) >= (longint'(1) << ADDR_W)) begin : g_bad_addr_w
        $error("conv_patch_scheduler: ADDR_W too narrow for IMG_W*IMG_H-1");
    end

    state_e            r_state;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_base_addr;
    logic [ADDR_W-1:0] r_out_addr;

    logic              w_start_pass;
    logic              w_step;
    logic              w_col_wrap;
    logic              w_row_wrap;
    logic              w_last;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_row;

    // A new pass starts only from IDLE or DONE; start during RUN is ignored.
    assign w_start_pass = start && (r_state != RUN);
    assign w_last       = (r_state == RUN) && w_col_wrap && w_row_wrap;
    // Patch counters move on adv in RUN, except on the final patch where they hold.
    assign w_step       = (r_state == RUN) && adv && !w_last;

    wrap_counter #(
        .WIDTH (ADDR_W),
        .MAX   (OUT_W - 1)
    ) u_col_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_pass),
        .en    (w_step),
        .count (w_col),
        .wrap  (w_col_wrap)
    );

    wrap_counter #(
        .WIDTH (ADDR_W),
        .MAX   (OUT_H - 1)
    ) u_row_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_pass),
        .en    (w_step && w_col_wrap),
        .count (w_row),
        .wrap  (w_row_wrap)
    );

    // Pass FSM with registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (adv && w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Incremental address generation: step along the row, or jump to the next row base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_base  <= '0;
            r_base_addr <= '0;
            r_out_addr  <= '0;
        end else if (w_start_pass) begin
            r_row_base  <= '0;
            r_base_addr <= '0;
            r_out_addr  <= '0;
        end else if (w_step) begin
            r_out_addr <= r_out_addr + 1'b1;
            if (w_col_wrap) begin
                r_row_base  <= r_row_base + ROW_STEP;
                r_base_addr <= r_row_base + ROW_STEP;
            end else begin
                r_base_addr <= r_base_addr + COL_STEP;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign base_addr  = r_base_addr;
    assign out_addr   = r_out_addr;
    assign patch_row  = w_row;
    assign patch_col  = w_col;
    assign last_patch = w_last;

endmodule

// File: doc/conv_patch_scheduler.md
# conv_patch_scheduler

Patch-position scheduler for the 3x3 convolution datapath. It walks output positions in raster order, using kernel size and stride, and gives the conv control FSM the input-window base address and output write address for the current patch. It advances one patch per `adv` pulse (the control FSM's `counter_enable`) and reports `done` so that FSM can park in CHECK_DONE. Start/busy/done handshake to the layer-level host.

## Interface
- `IMG_W`, 28: input feature-map width (pixels)
- `IMG_H`, 28: input feature-map height
- `K`, 3: kernel size; K <= IMG_W and K <= IMG_H, else elaboration error
- `STRIDE`, 1: window stride, >= 1
- `ADDR_W`, 10: width of `base_addr` and `out_addr`; must hold IMG_W*IMG_H-1, else elaboration error
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  single-cycle request to begin a new pass
- `adv`  in  1  advance to next patch (from control FSM `counter_enable`)
- `busy`  out  1  pass in progress
- `done`  out  1  level; all patches processed, held until next `start`
- `base_addr`  out  ADDR_W  input address of top-left pixel of current window
- `out_addr`  out  ADDR_W  linear output-map address of current patch
- `patch_row`  out  ADDR_W  current output row
- `patch_col`  out  ADDR_W  current output column
- `last_patch`  out  1  current patch is the final one of the pass

## Operation
- Derived: OUT_W = (IMG_W-K)/STRIDE+1, OUT_H = (IMG_H-K)/STRIDE+1, integer division.
- FSM states IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: busy=0, done=0. `start` -> RUN, all counters cleared to 0.
- RUN: busy=1. `adv` with col < OUT_W-1: col+1, base_addr += STRIDE, out_addr+1. `adv` with col = OUT_W-1 and row < OUT_H-1: col=0, row+1, row_base += STRIDE*IMG_W, base_addr = new row_base, out_addr+1. `adv` with `last_patch`=1: -> DONE, counters hold.
- DONE: done=1, busy=0, counters hold final patch values. `start` -> RUN with counters cleared.
- base_addr computed incrementally from a row_base register. No multiplier.
- `last_patch` = (row = OUT_H-1) and (col = OUT_W-1) and state = RUN; combinational from registers.
- `start` while in RUN: ignored. `adv` in IDLE/DONE: ignored.
- `start` and `adv` in the same cycle in DONE: `start` wins and `adv` is dropped.
- OUT_W = OUT_H = 1: first `adv` goes directly to DONE.
- Reset mid-pass: returns to IDLE immediately, all outputs 0, pass abandoned. There is no resume.
- Reset values: busy=0, done=0, base_addr=0, out_addr=0, patch_row=0, patch_col=0, last_patch=0.

## Timing
- All outputs are registered except `last_patch`.
- `start` sampled at edge t: busy=1 and addresses=0 visible after t, i.e. in cycle t+1.
- `adv` sampled at edge t: the new patch's addresses are valid in cycle t+1. The control FSM has at least one ADDR cycle before LOAD, so there is no stall.
- Final `adv` at edge t: done=1 and busy=0 from cycle t+1.
- Maximum sustained rate is one `adv` per cycle.

## Structure
- Shared `conv_pkg`: state enum typedef (IDLE/RUN/DONE), `out_dim(img, k, stride)` constant function.
- One sub-module, `wrap_counter`: parameterised MAX, `en`/`clr` inputs, `wrap` output. Instantiated for column and row. The address registers live in the top level.

## Test plan
- IMG 5x5, K=3, STRIDE=1. Send `start`, then 9 `adv` pulses with 7-cycle spacing -> base_addr sequence 0,1,2,5,6,7,10,11,12, out_addr 0..8. done=1 one cycle after the 9th `adv`.
- IMG 5x5, K=3, STRIDE=2. Send `start`, then 4 `adv` -> base_addr 0,2,10,12. `last_patch` high only with base 12. done then asserts.
- Back-to-back `adv` every cycle on 5x5/K=3 -> same 9-address sequence in 9 consecutive cycles. busy drops exactly on cycle 10.
- `start` pulsed mid-pass at patch 4 -> ignored, sequence continues. In DONE, `start` together with `adv` -> restart at base 0, out_addr 0, with no advance.
- Assert `rst_n` low at patch 5 -> all outputs 0 asynchronously. After release, `adv` alone -> no change. `start` -> pass restarts from 0.
- IMG 3x3, K=3 -> `last_patch`=1 right after `start`. One `adv` -> done=1.
